// File: rtl/match_decoder.sv
// ---------------------------------------------------------------------------
// match_decoder
//
// Sequential inverse of the quadrant matching stage. Given a reference
// quadrant set B0..B3 and the per-quadrant match indices, it rebuilds the
// original set A0..A3 by gathering a_k = B[idx_k], one quadrant per clock.
// Transactions enter and leave through valid/ready handshakes.
//
// Optional feature macro: MATCH_DECODE_PERM_CHECK_EN
//   defined   -> a used-index mask and a sticky error flag are built, and
//                perm_err reports a repeated index in idx0..idx3
//   undefined -> no mask or flag is built, and perm_err is tied to 0
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready only while IDLE)
//   b0..b3             reference quadrant codes (W bits each)
//   idx0..idx3         match index for each output quadrant (2 bits each)
//   out_valid/out_ready output handshake (out_valid only while DONE)
//   a0..a3             reconstructed quadrant codes
//   perm_err           idx vector was not a permutation (valid with out_valid)
//   busy               block is not IDLE
// ---------------------------------------------------------------------------
module match_decoder #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] b1,
    input  logic [W-1:0] b2,
    input  logic [W-1:0] b3,
    input  logic [1:0]   idx0,
    input  logic [1:0]   idx1,
    input  logic [1:0]   idx2,
    input  logic [1:0]   idx3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] a0,
    output logic [W-1:0] a1,
    output logic [W-1:0] a2,
    output logic [W-1:0] a3,
    output logic         perm_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;

    logic [W-1:0] r_b   [4];
    logic [1:0]   r_idx [4];
    logic [W-1:0] r_a   [4];
    logic [1:0]   r_cnt;

    logic         w_accept;
    logic [1:0]   w_sel;
    logic [W-1:0] w_val;

    // A new transaction is taken only while IDLE; in_valid elsewhere is
    // ignored so the latched B/idx stay untouched for the whole gather.
    assign w_accept = (r_state == IDLE) && in_valid;

    // The step counter names the output quadrant being rebuilt this cycle;
    // its index selects which latched reference code lands there.
    assign w_sel = r_idx[r_cnt];
    assign w_val = r_b[w_sel];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: four gather steps after accept, then hold in DONE
    // until downstream takes the result.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)      w_next = GATHER;
            GATHER:  if (r_cnt == 2'd3) w_next = DONE;
            DONE:    if (out_ready)     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: latch inputs on accept, then write one reconstructed
    // quadrant per GATHER cycle. The a registers are not cleared between
    // transactions, so they keep the last result until overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_b[i]   <= '0;
                r_idx[i] <= '0;
                r_a[i]   <= '0;
            end
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_b[0]   <= b0;
                r_b[1]   <= b1;
                r_b[2]   <= b2;
                r_b[3]   <= b3;
                r_idx[0] <= idx0;
                r_idx[1] <= idx1;
                r_idx[2] <= idx2;
                r_idx[3] <= idx3;
                r_cnt    <= '0;
            end else if (r_state == GATHER) begin
                r_a[r_cnt] <= w_val;
                r_cnt      <= r_cnt + 2'd1;
            end
        end
    end

`ifdef MATCH_DECODE_PERM_CHECK_EN
    logic [3:0] r_used;
    logic       r_errSticky;

    // Permutation check: every index must be used exactly once. Hitting an
    // index that is already marked sets the sticky flag, which is held
    // through DONE and cleared when the result is taken or a new
    // transaction starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used      <= '0;
            r_errSticky <= 1'b0;
        end else if (w_accept) begin
            r_used      <= '0;
            r_errSticky <= 1'b0;
        end else if (r_state == GATHER) begin
            r_used[w_sel] <= 1'b1;
            if (r_used[w_sel]) begin
                r_errSticky <= 1'b1;
            end
        end else if ((r_state == DONE) && out_ready) begin
            r_errSticky <= 1'b0;
        end
    end

    assign perm_err = r_errSticky;
`else
    assign perm_err = 1'b0;
`endif

    assign a0 = r_a[0];
    assign a1 = r_a[1];
    assign a2 = r_a[2];
    assign a3 = r_a[3];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_match_decoder.sv
// ---------------------------------------------------------------------------
// tb_match_decoder
//
// Self-checking bench for match_decoder. Expected results come from a
// behavioural model: a_k is the B code picked by idx_k, and a repeated
// index means the vector is not a permutation. Round-trip vectors are
// built by permuting B into A, deriving indices by searching B, and
// expecting A back.
// ---------------------------------------------------------------------------
module tb_match_decoder;

    localparam int W = 2;

`ifdef MATCH_DECODE_PERM_CHECK_EN
    localparam bit PERM_EN = 1'b1;
`else
    localparam bit PERM_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] b0, b1, b2, b3;
    logic [1:0]   idx0, idx1, idx2, idx3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a0, a1, a2, a3;
    logic         perm_err;
    logic         busy;

    int checkCount = 0;
    int failCount  = 0;

    match_decoder #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .b3        (b3),
        .idx0      (idx0),
        .idx1      (idx1),
        .idx2      (idx2),
        .idx3      (idx3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a0        (a0),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .perm_err  (perm_err),
        .busy      (busy)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference gather: quadrant k of the result is B at position idx_k.
    function automatic logic [4*W-1:0] modelA(input logic [4*W-1:0] bVec,
                                             input logic [7:0] idxVec);
        logic [4*W-1:0] res;
        int             ix;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            ix = int'(idxVec[2*k +: 2]);
            res[k*W +: W] = bVec[ix*W +: W];
        end
        return res;
    endfunction

    // Reference permutation check: any index appearing twice is an error.
    function automatic logic modelErr(input logic [7:0] idxVec);
        logic dup;
        dup = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (idxVec[2*i +: 2] == idxVec[2*j +: 2]) dup = 1'b1;
        return dup & PERM_EN;
    endfunction

    function automatic logic [4*W-1:0] outA();
        return {a3, a2, a1, a0};
    endfunction

    task automatic driveInputs(input logic [4*W-1:0] bVec, input logic [7:0] idxVec);
        b0   = bVec[0*W +: W];
        b1   = bVec[1*W +: W];
        b2   = bVec[2*W +: W];
        b3   = bVec[3*W +: W];
        idx0 = idxVec[1:0];
        idx1 = idxVec[3:2];
        idx2 = idxVec[5:4];
        idx3 = idxVec[7:6];
    endtask

    // Waits, bounded, for out_valid and returns the number of rising edges
    // seen since the call (called #1 after the accepting edge).
    task automatic waitResult(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // One complete transaction: offer it, check latency and result, hold
    // the result for 'stall' cycles, then hand it off downstream.
    task automatic applyStimulus(input string tag, input logic [4*W-1:0] bVec,
                                 input logic [7:0] idxVec,
                                 input logic [4*W-1:0] expA, input logic expErr,
                                 input int stall);
        int n;
        int lat;
        @(negedge clk);
        driveInputs(bVec, idxVec);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitResult(tag, lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_a"}, 32'(outA()), 32'(expA));
        checkOutput({tag, "_perm_err"}, 32'(perm_err), 32'(expErr));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_hold_a"}, 32'(outA()), 32'(expA));
        end
        out_ready = 1'b1;
        #1;
        checkOutput({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [4*W-1:0] bVec;
        logic [4*W-1:0] aVec;
        logic [4*W-1:0] bVec2;
        logic [7:0]     idxVec;
        logic [7:0]     idxVec2;
        int             permB[4];
        int             permP[4];
        int             tmp;
        int             j;
        int             lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        driveInputs('0, '0);
        #12;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_a", 32'(outA()), 32'd0);
        checkOutput("reset_perm_err", 32'(perm_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed: identity, reverse, duplicate index.
        applyStimulus("identity", {2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd2, 2'd1, 2'd0},
                      {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 0);
        applyStimulus("reverse", {2'd0, 2'd1, 2'd2, 2'd3}, {2'd0, 2'd1, 2'd2, 2'd3},
                      {2'd3, 2'd2, 2'd1, 2'd0}, 1'b0, 0);
        applyStimulus("duplicate", {2'd0, 2'd3, 2'd2, 2'd1}, {2'd2, 2'd1, 2'd0, 2'd0},
                      {2'd3, 2'd2, 2'd1, 2'd1}, PERM_EN, 0);

        // Backpressure: hold the result, offer a second transaction meanwhile
        // and make sure it waits until the first has been handed off.
        bVec    = {2'd2, 2'd0, 2'd3, 2'd1};
        idxVec  = {2'd1, 2'd1, 2'd3, 2'd2};
        bVec2   = {2'd1, 2'd3, 2'd0, 2'd2};
        idxVec2 = {2'd0, 2'd2, 2'd1, 2'd3};
        @(negedge clk);
        driveInputs(bVec, idxVec);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitResult("bp", lat);
        checkOutput("bp_latency", 32'(lat), 32'd4);
        driveInputs(bVec2, idxVec2);
        in_valid = 1'b1;
        for (int s = 0; s < 10; s++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_a", 32'(outA()), 32'(modelA(bVec, idxVec)));
            checkOutput("bp_hold_err", 32'(perm_err), 32'(modelErr(idxVec)));
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_second_accepted", 32'(busy), 32'd1);
        waitResult("bp2", lat);
        checkOutput("bp2_latency", 32'(lat), 32'd4);
        checkOutput("bp2_a", 32'(outA()), 32'(modelA(bVec2, idxVec2)));
        checkOutput("bp2_perm_err", 32'(perm_err), 32'(modelErr(idxVec2)));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset two edges into a gather: outputs must clear at once.
        @(negedge clk);
        driveInputs({2'd3, 2'd3, 2'd2, 2'd1}, {2'd0, 2'd1, 2'd2, 2'd3});
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_a", 32'(outA()), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("after_rst", {2'd1, 2'd2, 2'd3, 2'd0}, {2'd0, 2'd3, 2'd1, 2'd2},
                      modelA({2'd1, 2'd2, 2'd3, 2'd0}, {2'd0, 2'd3, 2'd1, 2'd2}), 1'b0, 2);

        // Random index vectors over random B, duplicates allowed.
        for (int t = 0; t < 200; t++) begin
            bVec   = (4*W)'($urandom);
            idxVec = 8'($urandom);
            applyStimulus("rand", bVec, idxVec, modelA(bVec, idxVec), modelErr(idxVec),
                          int'($urandom_range(2, 0)));
        end

        // Round trip: A is a permutation of distinct B; matching indices are
        // found by searching B for each A code, and A must come back.
        for (int t = 0; t < 1000; t++) begin
            for (int i = 0; i < 4; i++) begin
                permB[i] = i;
                permP[i] = i;
            end
            for (int i = 3; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                tmp = permB[i]; permB[i] = permB[j]; permB[j] = tmp;
                j = int'($urandom_range(i, 0));
                tmp = permP[i]; permP[i] = permP[j]; permP[j] = tmp;
            end
            for (int i = 0; i < 4; i++) begin
                bVec[i*W +: W] = W'(permB[i]);
                aVec[i*W +: W] = W'(permB[permP[i]]);
            end
            idxVec = '0;
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 4; i++)
                    if (bVec[i*W +: W] == aVec[k*W +: W]) idxVec[2*k +: 2] = 2'(i);
            applyStimulus("roundtrip", bVec, idxVec, aVec, 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
